prbs_core_lfsr: RTL and testbench
=================================

PRBS_CORE_LFSR -- requirements
Module: prbs_core_lfsr

Interface
REQ-001 Parameter ACC_WIDTH, default 32, is the width of the bit-rate phase accumulator and of prbs_rate_ftw.
REQ-002 Parameter SEED_DEFAULT, default 31'h7FFF_FFFF, is the LFSR state loaded at reset.
REQ-003 dac_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 prbs_run  in  1  high = accumulator advances; low = freeze.
REQ-006 prbs_order_sel  in  3  selects the polynomial: 0=PRBS7 (x^7+x^6+1), 1=PRBS9 (x^9+x^5+1), 2=PRBS11 (x^11+x^9+1), 3=PRBS15 (x^15+x^14+1), 4=PRBS20 (x^20+x^3+1), 5=PRBS23 (x^23+x^18+1), 6=PRBS31 (x^31+x^28+1), 7=PRBS7.
REQ-007 prbs_rate_ftw  in  ACC_WIDTH  bit-rate tuning word; bit rate = f_dac_clk*ftw/2^ACC_WIDTH.
REQ-008 prbs_seed  in  31  seed value; the low N bits are used.
REQ-009 prbs_seed_load  in  1  one-cycle pulse that loads prbs_seed.
REQ-010 prbs_invert  in  1  inverts every emitted bit.
REQ-011 prbs_err_inject  in  1  one-cycle pulse that flips one emitted bit.
REQ-012 prbs_bit_out  out  1  registered PRBS bit; feeds the edge shaper.
REQ-013 lfsr_clk_enable  out  1  one-cycle strobe marking a new prbs_bit_out.
REQ-014 prbs_sync  out  1  one-cycle pattern-start marker, coincident with lfsr_clk_enable.
REQ-015 lfsr_state_dbg  out  31  current LFSR state, zero-extended above N.

Function
REQ-016 Accumulator: when prbs_run=1, acc <= acc + ftw (mod 2^ACC_WIDTH) every cycle; tick = carry-out of that add.
REQ-017 In the cycle a tick occurs, the following edge registers lfsr_clk_enable=1; otherwise lfsr_clk_enable=0; ftw=0 means no strobes ever.
REQ-018 prbs_run=0: acc holds, lfsr_clk_enable=0, LFSR, prbs_bit_out and the pending flag hold.
REQ-019 LFSR is Fibonacci over s[N-1:0]: fb = s[N-1] ^ s[T-1] (N, T from REQ-006); on a tick, s <= {s[N-2:0], fb}, with bits >= N forced to 0.
REQ-020 On the same edge as the strobe, prbs_bit_out <= fb ^ prbs_invert ^ flip; the bit is stable until the next strobe, so lfsr_clk_enable and prbs_bit_out change together.
REQ-021 Error injection: prbs_err_inject sets a pending flag; flip = pending OR (prbs_err_inject this cycle); the flag clears on the emitting edge; multiple pulses before one emission produce a single flip; the LFSR state is never altered.
REQ-022 Lockup guard: if the masked state is all-zero at any edge (after a load, after an order change, or otherwise), the state becomes all-ones in N bits on that edge and no bit is emitted.
REQ-023 Seed load: prbs_seed_load has priority over shifting; it sets s <= prbs_seed masked to N bits (zero becomes all-ones), acc <= 0 and pending <= 0, suppresses the strobe that cycle and holds prbs_bit_out.
REQ-024 An order change takes effect on the next tick without a reload; upper state bits are masked.
REQ-025 prbs_sync=1 with the strobe when the post-shift masked state equals all-ones, i.e. once per 2^N-1 strobes.
REQ-026 Reset and seed_load asserted together: reset wins.

Reset
REQ-027 While reset=1 at an edge: acc=0, s=SEED_DEFAULT masked, pending=0, prbs_bit_out=0, lfsr_clk_enable=0, prbs_sync=0.
REQ-028 Reset mid-run discards any partial accumulator phase and the pending error; the first strobe after release follows REQ-016/017 from acc=0.

Verification
REQ-029 Reset, PRBS7, ftw=0x8000_0000, run=1 -> strobe every 2nd cycle; first seven bits 0,0,0,0,0,0,1; prbs_sync every 127 strobes.
REQ-030 ftw=0x4000_0000 -> exactly 256 strobes in 1024 cycles, evenly spaced 4 apart; ftw=0 -> zero strobes.
REQ-031 PRBS9, ftw=0xFFFF_FFFF, compare against a golden model over 2044 strobes -> exact match; prbs_sync every 511 strobes; invert=1 -> bitwise complement.
REQ-032 seed_load with prbs_seed=0 on PRBS15 -> lfsr_state_dbg=0x7FFF; the sequence continues and never sticks at 0.
REQ-033 Two err_inject pulses before one strobe -> exactly one bit differs from golden; later bits match; lfsr_state_dbg matches golden.
REQ-034 Reset mid-run on PRBS23 -> all outputs 0 on the next cycle; the sequence restarts identical to the post-power-up sequence.

Source files
------------

// File: rtl/prbs_core_lfsr.sv
// ----------------------------------------------------------------------------
// prbs_core_lfsr
//
// Programmable-order PRBS generator clocked by a DAC clock. A phase
// accumulator sets the bit rate (f_dac_clk * ftw / 2^ACC_WIDTH). Each carry
// out of the accumulator shifts a Fibonacci LFSR once and registers one new
// output bit.
//
// Parameters
//   ACC_WIDTH     width of the phase accumulator and of prbs_rate_ftw
//   SEED_DEFAULT  LFSR state loaded at reset (masked to the selected order)
//
// Ports
//   dac_clk          in   clock, rising edge
//   reset            in   synchronous active-high reset
//   prbs_run         in   1 = accumulator advances, 0 = everything freezes
//   prbs_order_sel   in   polynomial: 0/7=PRBS7 1=PRBS9 2=PRBS11 3=PRBS15
//                         4=PRBS20 5=PRBS23 6=PRBS31
//   prbs_rate_ftw    in   bit-rate tuning word
//   prbs_seed        in   seed, low N bits used
//   prbs_seed_load   in   pulse: load prbs_seed, clear phase and pending error
//   prbs_invert      in   complement every emitted bit
//   prbs_err_inject  in   pulse: flip the next emitted bit
//   prbs_bit_out     out  registered PRBS bit
//   lfsr_clk_enable  out  one-cycle strobe, high on the edge a new bit appears
//   prbs_sync        out  pattern-start marker, coincident with the strobe
//   lfsr_state_dbg   out  current LFSR state, zero above bit N-1
// ----------------------------------------------------------------------------
module prbs_core_lfsr #(
    parameter int          ACC_WIDTH    = 32,
    parameter logic [30:0] SEED_DEFAULT = 31'h7FFF_FFFF
) (
    input  logic                 dac_clk,
    input  logic                 reset,
    input  logic                 prbs_run,
    input  logic [2:0]           prbs_order_sel,
    input  logic [ACC_WIDTH-1:0] prbs_rate_ftw,
    input  logic [30:0]          prbs_seed,
    input  logic                 prbs_seed_load,
    input  logic                 prbs_invert,
    input  logic                 prbs_err_inject,
    output logic                 prbs_bit_out,
    output logic                 lfsr_clk_enable,
    output logic                 prbs_sync,
    output logic [30:0]          lfsr_state_dbg
);

    // Polynomial description: register length N and second tap T.
    typedef struct packed {
        logic [4:0] len;
        logic [4:0] tap;
    } poly_t;

    logic [ACC_WIDTH-1:0] acc;
    logic [30:0]          state;
    logic                 pending;

    poly_t                poly;
    logic [30:0]          mask;
    logic [30:0]          masked;
    logic [30:0]          shifted;
    logic [30:0]          seed_masked;
    logic [30:0]          seed_next;
    logic [ACC_WIDTH:0]   sum;
    logic                 tick;
    logic                 fb;
    logic                 flip;
    logic                 locked;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first, or a full case with default) so no latch is inferred.
    always_comb begin
        poly = '{len: 5'd7, tap: 5'd6};
        case (prbs_order_sel)
            3'd0:    poly = '{len: 5'd7,  tap: 5'd6};
            3'd1:    poly = '{len: 5'd9,  tap: 5'd5};
            3'd2:    poly = '{len: 5'd11, tap: 5'd9};
            3'd3:    poly = '{len: 5'd15, tap: 5'd14};
            3'd4:    poly = '{len: 5'd20, tap: 5'd3};
            3'd5:    poly = '{len: 5'd23, tap: 5'd18};
            3'd6:    poly = '{len: 5'd31, tap: 5'd28};
            default: poly = '{len: 5'd7,  tap: 5'd6};
        endcase
    end

    always_comb begin
        // N ones in the low bits; len is at most 31 so the shift never wraps.
        mask        = 31'h7FFF_FFFF >> (5'd31 - poly.len);
        // Masking on read makes an order change effective immediately,
        // without a reload.
        masked      = state & mask;
        locked      = (masked == 31'd0);
        fb          = masked[poly.len - 5'd1] ^ masked[poly.tap - 5'd1];
        shifted     = ((masked << 1) | {30'd0, fb}) & mask;
        seed_masked = prbs_seed & mask;
        seed_next   = (seed_masked == 31'd0) ? mask : seed_masked;
        sum         = {1'b0, acc} + {1'b0, prbs_rate_ftw};
        tick        = prbs_run & sum[ACC_WIDTH];
        // Several inject pulses before one emission merge into one flip.
        flip        = pending | prbs_err_inject;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge dac_clk) begin
        if (reset) begin
            acc             <= '0;
            state           <= SEED_DEFAULT & mask;
            pending         <= 1'b0;
            prbs_bit_out    <= 1'b0;
            lfsr_clk_enable <= 1'b0;
            prbs_sync       <= 1'b0;
        end else if (prbs_seed_load) begin
            // Load wins over shifting; the bit output holds and the phase
            // restarts from zero.
            acc             <= '0;
            state           <= seed_next;
            pending         <= 1'b0;
            lfsr_clk_enable <= 1'b0;
            prbs_sync       <= 1'b0;
        end else begin
            lfsr_clk_enable <= 1'b0;
            prbs_sync       <= 1'b0;
            if (prbs_run) begin
                acc <= sum[ACC_WIDTH-1:0];
            end
            if (locked) begin
                // All-zero is the LFSR's stuck state: escape to all-ones and
                // drop this tick rather than emit a bit from a dead register.
                state <= mask;
                if (prbs_run) begin
                    pending <= flip;
                end
            end else if (tick) begin
                state           <= shifted;
                prbs_bit_out    <= fb ^ prbs_invert ^ flip;
                pending         <= 1'b0;
                lfsr_clk_enable <= 1'b1;
                prbs_sync       <= (shifted == mask);
            end else if (prbs_run) begin
                pending <= flip;
            end
        end
    end

    assign lfsr_state_dbg = masked;

endmodule

// File: tb/tb_prbs_core_lfsr.sv
module tb_prbs_core_lfsr;

    logic        dac_clk = 1'b0;
    logic        reset;
    logic        prbs_run;
    logic [2:0]  prbs_order_sel;
    logic [31:0] prbs_rate_ftw;
    logic [30:0] prbs_seed;
    logic        prbs_seed_load;
    logic        prbs_invert;
    logic        prbs_err_inject;
    logic        prbs_bit_out;
    logic        lfsr_clk_enable;
    logic        prbs_sync;
    logic [30:0] lfsr_state_dbg;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Golden LFSR state and selected order.
    logic [30:0] gs;
    int          gsel;
    logic        obs_bit;
    int          sync_seen;
    int          strobe_idx;
    int          last_sync_idx;

    prbs_core_lfsr #(.ACC_WIDTH(32), .SEED_DEFAULT(31'h7FFF_FFFF)) dut (
        .dac_clk         (dac_clk),
        .reset           (reset),
        .prbs_run        (prbs_run),
        .prbs_order_sel  (prbs_order_sel),
        .prbs_rate_ftw   (prbs_rate_ftw),
        .prbs_seed       (prbs_seed),
        .prbs_seed_load  (prbs_seed_load),
        .prbs_invert     (prbs_invert),
        .prbs_err_inject (prbs_err_inject),
        .prbs_bit_out    (prbs_bit_out),
        .lfsr_clk_enable (lfsr_clk_enable),
        .prbs_sync       (prbs_sync),
        .lfsr_state_dbg  (lfsr_state_dbg)
    );

    always #5 dac_clk = ~dac_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic int glen(input int sel);
        case (sel)
            1: return 9;   2: return 11;  3: return 15;
            4: return 20;  5: return 23;  6: return 31;
            default: return 7;
        endcase
    endfunction

    function automatic int gtap(input int sel);
        case (sel)
            1: return 5;   2: return 9;   3: return 14;
            4: return 3;   5: return 18;  6: return 28;
            default: return 6;
        endcase
    endfunction

    function automatic logic [30:0] gmask(input int sel);
        logic [63:0] m;
        m = (64'd1 << glen(sel)) - 64'd1;
        return m[30:0];
    endfunction

    function automatic logic gfb(input logic [30:0] s, input int sel);
        return s[glen(sel) - 1] ^ s[gtap(sel) - 1];
    endfunction

    function automatic logic [30:0] gnext(input logic [30:0] s, input int sel);
        return ((s << 1) | {30'd0, gfb(s, sel)}) & gmask(sel);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge dac_clk);
        #1;
    endtask

    // Waits for the next strobe and checks bit, state and sync against the
    // golden model. gap = number of edges from call to strobe.
    task automatic expect_strobe(input string tag, input int max_wait,
                                 input logic flip, output int gap);
        logic expb;
        gap = 0;
        do begin
            step();
            gap++;
        end while (!lfsr_clk_enable && gap < max_wait);
        if (!lfsr_clk_enable) begin
            check({tag, "_timeout"}, {31'd0, lfsr_clk_enable}, 32'd1);
            return;
        end
        expb = gfb(gs, gsel) ^ prbs_invert ^ flip;
        gs   = gnext(gs, gsel);
        strobe_idx++;
        check({tag, "_bit"},  {31'd0, prbs_bit_out}, {31'd0, expb});
        check({tag, "_dbg"},  {1'b0, lfsr_state_dbg}, {1'b0, gs});
        check({tag, "_sync"}, {31'd0, prbs_sync}, {31'd0, gs == gmask(gsel)});
        obs_bit = prbs_bit_out;
        if (prbs_sync) begin
            sync_seen++;
            last_sync_idx = strobe_idx;
        end
    endtask

    initial begin
        int          gap;
        int          cnt;
        int          bad_gap;
        int          last;
        logic [6:0]  first7;
        logic        held_bit;
        logic [30:0] held_dbg;

        reset = 1'b1;           prbs_run = 1'b0;
        prbs_order_sel = 3'd0;  prbs_rate_ftw = 32'h8000_0000;
        prbs_seed = '0;         prbs_seed_load = 1'b0;
        prbs_invert = 1'b0;     prbs_err_inject = 1'b0;
        step();
        step();

        // Reset state, PRBS7
        check("rst_bit",  {31'd0, prbs_bit_out}, 32'd0);
        check("rst_en",   {31'd0, lfsr_clk_enable}, 32'd0);
        check("rst_sync", {31'd0, prbs_sync}, 32'd0);
        check("rst_dbg",  {1'b0, lfsr_state_dbg}, 32'h7F);

        // PRBS7 at half rate: strobe every 2nd edge, known first bits
        gs = 31'h7F; gsel = 0; sync_seen = 0; strobe_idx = 0; last_sync_idx = 0;
        reset = 1'b0; prbs_run = 1'b1;
        bad_gap = 0;
        for (int i = 0; i < 254; i++) begin
            expect_strobe("p7", 4, 1'b0, gap);
            if (gap != 2) bad_gap++;
            if (i < 7) first7 = {first7[5:0], obs_bit};
        end
        check("p7_first7", {25'd0, first7}, 32'b0000001);
        check("p7_gaps", bad_gap, 0);
        check("p7_sync_cnt", sync_seen, 2);
        check("p7_sync_last", last_sync_idx, 254);

        // Quarter rate: 256 strobes in 1024 cycles, spaced 4
        reset = 1'b1; prbs_rate_ftw = 32'h4000_0000;
        step();
        reset = 1'b0;
        cnt = 0; bad_gap = 0; last = 0;
        for (int c = 1; c <= 1024; c++) begin
            step();
            if (lfsr_clk_enable) begin
                cnt++;
                if (c - last != 4) bad_gap++;
                last = c;
            end
        end
        check("q_count", cnt, 256);
        check("q_gaps", bad_gap, 0);

        // ftw = 0: no strobes at all
        prbs_rate_ftw = 32'h0;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (lfsr_clk_enable) cnt++;
        end
        check("ftw0_count", cnt, 0);

        // PRBS9 at near full rate against the golden model
        reset = 1'b1; prbs_order_sel = 3'd1; prbs_rate_ftw = 32'hFFFF_FFFF;
        step();
        check("p9_rst_dbg", {1'b0, lfsr_state_dbg}, 32'h1FF);
        reset = 1'b0;
        gs = 31'h1FF; gsel = 1; sync_seen = 0; strobe_idx = 0;
        for (int i = 0; i < 2044; i++) expect_strobe("p9", 4, 1'b0, gap);
        check("p9_sync_cnt", sync_seen, 4);
        check("p9_sync_last", last_sync_idx, 2044);

        // Inversion: complement of the golden sequence
        prbs_invert = 1'b1;
        for (int i = 0; i < 20; i++) expect_strobe("p9_inv", 4, 1'b0, gap);
        prbs_invert = 1'b0;

        // Seed load resets phase; then two inject pulses before one strobe
        prbs_rate_ftw = 32'h4000_0000; prbs_seed = 31'h0A5; prbs_seed_load = 1'b1;
        held_bit = prbs_bit_out;
        step();
        prbs_seed_load = 1'b0;
        check("ld9_dbg", {1'b0, lfsr_state_dbg}, 32'h0A5);
        check("ld9_en", {31'd0, lfsr_clk_enable}, 32'd0);
        check("ld9_hold", {31'd0, prbs_bit_out}, {31'd0, held_bit});
        gs = 31'h0A5;
        expect_strobe("inj_pre", 8, 1'b0, gap);
        check("inj_pre_gap", gap, 4);
        prbs_err_inject = 1'b1; step();
        prbs_err_inject = 1'b0; step();
        prbs_err_inject = 1'b1; step();
        prbs_err_inject = 1'b0;
        expect_strobe("inj_flip", 4, 1'b1, gap);
        for (int i = 0; i < 4; i++) expect_strobe("inj_post", 8, 1'b0, gap);

        // Freeze: nothing moves while prbs_run = 0
        prbs_run = 1'b0;
        held_bit = prbs_bit_out; held_dbg = lfsr_state_dbg;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (lfsr_clk_enable) cnt++;
        end
        check("frz_strobes", cnt, 0);
        check("frz_bit", {31'd0, prbs_bit_out}, {31'd0, held_bit});
        check("frz_dbg", {1'b0, lfsr_state_dbg}, {1'b0, held_dbg});
        prbs_run = 1'b1;
        for (int i = 0; i < 3; i++) expect_strobe("frz_resume", 8, 1'b0, gap);

        // Zero seed on PRBS15 becomes all-ones; sequence continues
        prbs_order_sel = 3'd3; prbs_seed = 31'h0; prbs_seed_load = 1'b1;
        held_bit = prbs_bit_out;
        step();
        prbs_seed_load = 1'b0;
        check("ld15_dbg", {1'b0, lfsr_state_dbg}, 32'h7FFF);
        check("ld15_en", {31'd0, lfsr_clk_enable}, 32'd0);
        check("ld15_hold", {31'd0, prbs_bit_out}, {31'd0, held_bit});
        gs = 31'h7FFF; gsel = 3;
        for (int i = 0; i < 100; i++) expect_strobe("p15", 8, 1'b0, gap);

        // Order change onto an all-zero masked state triggers the guard
        prbs_run = 1'b0;
        prbs_order_sel = 3'd2; prbs_seed = 31'h100; prbs_seed_load = 1'b1;
        step();
        prbs_seed_load = 1'b0;
        check("ord_ld_dbg", {1'b0, lfsr_state_dbg}, 32'h100);
        prbs_order_sel = 3'd0;
        #1;
        check("ord_masked", {1'b0, lfsr_state_dbg}, 32'h0);
        step();
        check("ord_guard_dbg", {1'b0, lfsr_state_dbg}, 32'h7F);
        check("ord_guard_en", {31'd0, lfsr_clk_enable}, 32'd0);
        prbs_run = 1'b1;
        gs = 31'h7F; gsel = 0;
        for (int i = 0; i < 10; i++) expect_strobe("ord_p7", 8, 1'b0, gap);

        // PRBS23: reset mid-run restarts the identical sequence
        prbs_order_sel = 3'd5; prbs_rate_ftw = 32'h8000_0000; reset = 1'b1;
        step();
        reset = 1'b0;
        gs = 31'h7F_FFFF; gsel = 5;
        expect_strobe("p23_a", 4, 1'b0, gap);
        check("p23_a_gap", gap, 2);
        for (int i = 0; i < 29; i++) expect_strobe("p23_a", 4, 1'b0, gap);
        prbs_err_inject = 1'b1;
        step();                 // acc now mid-phase, error pending
        prbs_err_inject = 1'b0;
        reset = 1'b1;
        step();
        check("p23_rst_bit",  {31'd0, prbs_bit_out}, 32'd0);
        check("p23_rst_en",   {31'd0, lfsr_clk_enable}, 32'd0);
        check("p23_rst_sync", {31'd0, prbs_sync}, 32'd0);
        check("p23_rst_dbg",  {1'b0, lfsr_state_dbg}, 32'h7F_FFFF);
        reset = 1'b0;
        gs = 31'h7F_FFFF;
        expect_strobe("p23_b", 4, 1'b0, gap);
        check("p23_b_gap", gap, 2);
        for (int i = 0; i < 29; i++) expect_strobe("p23_b", 4, 1'b0, gap);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
